design_switch_sequencer: RTL and testbench

Sequences a safe hand-over of the shared pad ring between user designs. It accepts a design-change request from the Wishbone register side, then runs a fixed sequence: hold the current design in reset, isolate the pads, switch `design_select`, hold the new design in reset, and release. It sits between the Wishbone control register and the output multiplexer, and drives the multiplexer's select, forced-reset and pad-isolation controls.

---
 rtl/design_mux_pkg.sv | 27 ++
 rtl/seq_down_counter.sv | 28 ++
 rtl/design_switch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_design_switch_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/design_mux_pkg.sv
// Shared types and constants for the pad-ring design multiplexer and its switch sequencer.
package design_mux_pkg;

    localparam int DESIGN_ID_W = 4;

    localparam logic [DESIGN_ID_W-1:0] DESIGN_NONE     = 4'd0;
    localparam logic [DESIGN_ID_W-1:0] DESIGN_Z80      = 4'd1;
    localparam logic [DESIGN_ID_W-1:0] DESIGN_SCRAPCPU = 4'd2;
    localparam logic [DESIGN_ID_W-1:0] DESIGN_VLIW     = 4'd3;
    localparam logic [DESIGN_ID_W-1:0] DESIGN_M6502    = 4'd4;
    localparam logic [DESIGN_ID_W-1:0] DESIGN_AS1802   = 4'd5;
    localparam logic [DESIGN_ID_W-1:0] DESIGN_I8X305   = 4'd6;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_ISOLATE = 3'd1,
        SEQ_SWITCH  = 3'd2,
        SEQ_HOLD    = 3'd3,
        SEQ_RELEASE = 3'd4
    } seq_state_t;

    // Counter width able to hold max_count-1; never narrower than one bit.
    function automatic int counter_width(input int max_count);
        return (max_count > 2) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module seq_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/design_switch_sequencer.sv
// Safe hand-over of the shared pad ring: reset, isolate, switch, hold, release.
// Optional watchdog auto-restart of the active design is built when SEQ_WATCHDOG_EN is defined.
module design_switch_sequencer
    import design_mux_pkg::*;
#(
    parameter int NUM_DESIGNS     = 7,
    parameter int GUARD_CYCLES    = 16,
    parameter int RST_HOLD_CYCLES = 64,
    parameter int WDT_CYCLES      = 65535
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   req_valid,
    input  logic [DESIGN_ID_W-1:0] req_design,
    output logic                   req_ready,
    output logic                   req_err,
    input  logic                   wdt_kick,
    output logic [DESIGN_ID_W-1:0] design_select,
    output logic                   rst_force,
    output logic                   pad_iso,
    output logic                   done,
    output logic [2:0]             seq_state
);

    localparam int TMR_MAX = (GUARD_CYCLES > RST_HOLD_CYCLES) ? GUARD_CYCLES : RST_HOLD_CYCLES;
    localparam int TMR_W   = counter_width(TMR_MAX);
    localparam logic [TMR_W-1:0]       GUARD_LOAD = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [TMR_W-1:0]       HOLD_LOAD  = TMR_W'(RST_HOLD_CYCLES - 1);
    localparam logic [DESIGN_ID_W:0]   ID_LIMIT   = (DESIGN_ID_W + 1)'(NUM_DESIGNS);

    seq_state_t             r_state;
    seq_state_t             w_state_next;
    logic [DESIGN_ID_W-1:0] r_design_select;
    logic [DESIGN_ID_W-1:0] r_pending;
    logic                   r_rst_force;
    logic                   r_pad_iso;
    logic                   r_done;
    logic                   r_req_err;

    logic                   w_req_in_range;
    logic                   w_accept;
    logic [DESIGN_ID_W-1:0] w_accept_id;
    logic                   w_req_err_next;
    logic                   w_iso_next;
    logic                   w_tmr_load;
    logic [TMR_W-1:0]       w_tmr_load_val;
    logic                   w_tmr_dec;
    logic                   w_tmr_zero;
    logic                   w_wdt_fire;

    assign w_req_in_range = ({1'b0, req_design} < ID_LIMIT);

    seq_down_counter #(.WIDTH(TMR_W)) u_phase_timer (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

`ifdef SEQ_WATCHDOG_EN
    localparam int WDT_W = counter_width(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES - 1);

    logic w_wdt_run;
    logic w_wdt_zero;

    // Counts only while a real design sits idle; any kick or leaving IDLE reloads it.
    assign w_wdt_run = (r_state == SEQ_IDLE) && (r_design_select != DESIGN_NONE);

    seq_down_counter #(.WIDTH(WDT_W)) u_watchdog (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_load     (!w_wdt_run || wdt_kick),
        .i_load_val (WDT_LOAD),
        .i_dec      (w_wdt_run),
        .o_zero     (w_wdt_zero)
    );

    assign w_wdt_fire = w_wdt_run && w_wdt_zero && !wdt_kick;
`else
    logic w_unused_wdt;

    assign w_wdt_fire   = 1'b0;
    assign w_unused_wdt = wdt_kick | (WDT_CYCLES == 0);
`endif

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_accept_id    = r_pending;
        w_req_err_next = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = GUARD_LOAD;
        w_tmr_dec      = 1'b0;

        unique case (r_state)
            SEQ_IDLE: begin
                if (req_valid && w_req_in_range) begin
                    w_accept     = 1'b1;
                    w_accept_id  = req_design;
                    w_tmr_load   = 1'b1;
                    w_state_next = SEQ_ISOLATE;
                end else if (req_valid) begin
                    w_req_err_next = 1'b1;
                end else if (w_wdt_fire) begin
                    w_accept     = 1'b1;
                    w_accept_id  = r_design_select;
                    w_tmr_load   = 1'b1;
                    w_state_next = SEQ_ISOLATE;
                end
            end
            SEQ_ISOLATE: begin
                w_tmr_dec = 1'b1;
                if (w_tmr_zero) w_state_next = SEQ_SWITCH;
            end
            SEQ_SWITCH: begin
                w_tmr_load     = 1'b1;
                w_tmr_load_val = HOLD_LOAD;
                w_state_next   = SEQ_HOLD;
            end
            SEQ_HOLD: begin
                w_tmr_dec = 1'b1;
                if (w_tmr_zero) w_state_next = SEQ_RELEASE;
            end
            SEQ_RELEASE: begin
                w_state_next = SEQ_IDLE;
            end
            default: begin
                w_state_next = SEQ_IDLE;
            end
        endcase
    end

    assign w_iso_next = (w_state_next == SEQ_ISOLATE) ||
                        (w_state_next == SEQ_SWITCH)  ||
                        (w_state_next == SEQ_HOLD);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state         <= SEQ_IDLE;
            r_design_select <= DESIGN_NONE;
            r_pending       <= DESIGN_NONE;
            r_rst_force     <= 1'b0;
            r_pad_iso       <= 1'b0;
            r_done          <= 1'b0;
            r_req_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rst_force <= w_iso_next;
            r_pad_iso   <= w_iso_next;
            r_done      <= (r_state == SEQ_RELEASE);
            r_req_err   <= w_req_err_next;
            if (w_accept) r_pending <= w_accept_id;
            // The select only moves mid-sequence, so the pads are always isolated when it does.
            if (r_state == SEQ_SWITCH) r_design_select <= r_pending;
        end
    end

    assign req_ready     = (r_state == SEQ_IDLE);
    assign req_err       = r_req_err;
    assign design_select = r_design_select;
    assign rst_force     = r_rst_force;
    assign pad_iso       = r_pad_iso;
    assign done          = r_done;
    assign seq_state     = r_state;

endmodule

// File: tb/tb_design_switch_sequencer.sv
// Self-checking bench: directed scenarios plus randomized requests against a timeline model.
module tb_design_switch_sequencer;

    localparam int N  = 7;
    localparam int G  = 16;
    localparam int H  = 64;
    localparam int GM = 1;
    localparam int HM = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       req_valid, wdt_kick, req_ready, req_err, rst_force, pad_iso, done;
    logic [3:0] req_design, design_select;
    logic [2:0] seq_state;

    logic       s_req_valid, s_wdt_kick, s_req_ready, s_req_err, s_rst_force, s_pad_iso, s_done;
    logic [3:0] s_req_design, s_design_select;
    logic [2:0] s_seq_state;

    int n_cmp = 0;
    int n_bad = 0;

    design_switch_sequencer dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid), .req_design(req_design),
        .req_ready(req_ready), .req_err(req_err), .wdt_kick(wdt_kick),
        .design_select(design_select), .rst_force(rst_force),
        .pad_iso(pad_iso), .done(done), .seq_state(seq_state)
    );

    design_switch_sequencer #(.GUARD_CYCLES(GM), .RST_HOLD_CYCLES(HM)) dut_small (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(s_req_valid), .req_design(s_req_design),
        .req_ready(s_req_ready), .req_err(s_req_err), .wdt_kick(s_wdt_kick),
        .design_select(s_design_select), .rst_force(s_rst_force),
        .pad_iso(s_pad_iso), .done(s_done), .seq_state(s_seq_state)
    );

    // Timeline model: md_rel counts clock edges since the last accepted request (-1: none yet).
    int         md_rel;
    logic [3:0] md_pend, md_old;
    logic       md_err, md_acc;

    function automatic logic [3:0] exp_sel();
        return (md_rel >= G + 1) ? md_pend : md_old;
    endfunction

    function automatic logic exp_busy();
        return (md_rel >= 0) && (md_rel <= G + H + 1);
    endfunction

    function automatic logic exp_pad();
        return (md_rel >= 0) && (md_rel <= G + H);
    endfunction

    function automatic logic exp_done();
        return md_rel == G + H + 2;
    endfunction

    function automatic logic [2:0] exp_state();
        if (!exp_busy())          return 3'd0;
        if (md_rel < G)           return 3'd1;
        if (md_rel == G)          return 3'd2;
        if (md_rel <= G + H)      return 3'd3;
        return 3'd4;
    endfunction

    task automatic model_reset();
        md_rel = -1; md_pend = 4'd0; md_old = 4'd0; md_err = 1'b0; md_acc = 1'b0;
    endtask

    task automatic model_edge();
        logic idle;
        idle   = !exp_busy();
        md_err = 1'b0;
        md_acc = 1'b0;
        if (idle && req_valid && int'(req_design) < N) begin
            md_old  = exp_sel();
            md_pend = req_design;
            md_rel  = 0;
            md_acc  = 1'b1;
        end else begin
            if (idle && req_valid) md_err = 1'b1;
            if (md_rel >= 0 && md_rel < 100000) md_rel++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_design = 4'd0; wdt_kick = 1'b0;
        s_req_valid = 1'b0; s_req_design = 4'd0; s_wdt_kick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (seq_state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", seq_state); end
        n_cmp++; if (design_select !== 4'd0) begin n_bad++; $display("FAIL reset_select got %0d exp 0", design_select); end
        n_cmp++; if ({rst_force, pad_iso, done, req_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_outputs got %b exp 0000", {rst_force, pad_iso, done, req_err}); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        n_cmp++; if ({s_seq_state, s_design_select, s_pad_iso, s_done} !== 9'd0) begin n_bad++; $display("FAIL reset_small got %b exp 0", {s_seq_state, s_design_select, s_pad_iso, s_done}); end
    endtask

    task automatic test_first_sequence();
        int sel_rel = -1;
        int done_rel = -1;
        req_design = 4'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (pad_iso !== 1'b1) begin n_bad++; $display("FAIL first_pad_iso got %b exp 1", pad_iso); end
        n_cmp++; if (rst_force !== 1'b1) begin n_bad++; $display("FAIL first_rst_force got %b exp 1", rst_force); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL first_ready_low got %b exp 0", req_ready); end
        for (int rel = 1; rel <= G + H + 3; rel++) begin
            tick();
            if (design_select === 4'd3 && sel_rel < 0) sel_rel = rel;
            if (done === 1'b1 && done_rel < 0) done_rel = rel;
            n_cmp++; if (done !== exp_done()) begin n_bad++; $display("FAIL first_done rel=%0d got %b exp %b", rel, done, exp_done()); end
            n_cmp++; if (pad_iso !== exp_pad()) begin n_bad++; $display("FAIL first_pad rel=%0d got %b exp %b", rel, pad_iso, exp_pad()); end
        end
        n_cmp++; if (sel_rel !== G + 1) begin n_bad++; $display("FAIL first_select_time got %0d exp %0d", sel_rel, G + 1); end
        n_cmp++; if (done_rel !== G + H + 2) begin n_bad++; $display("FAIL first_done_time got %0d exp %0d", done_rel, G + H + 2); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL first_ready_back got %b exp 1", req_ready); end
    endtask

    task automatic test_reject();
        logic [3:0] bad_ids [3] = '{4'd7, 4'd9, 4'd15};
        for (int i = 0; i < 3; i++) begin
            req_design = bad_ids[i]; req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            n_cmp++; if (req_err !== 1'b1) begin n_bad++; $display("FAIL reject_err id=%0d got %b exp 1", bad_ids[i], req_err); end
            n_cmp++; if (seq_state !== 3'd0) begin n_bad++; $display("FAIL reject_state id=%0d got %0d exp 0", bad_ids[i], seq_state); end
            n_cmp++; if (design_select !== 4'd3) begin n_bad++; $display("FAIL reject_select id=%0d got %0d exp 3", bad_ids[i], design_select); end
            n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reject_ready id=%0d got %b exp 1", bad_ids[i], req_ready); end
            tick();
            n_cmp++; if (req_err !== 1'b0) begin n_bad++; $display("FAIL reject_pulse_width id=%0d got %b exp 0", bad_ids[i], req_err); end
        end
    endtask

    task automatic test_hold_ignored();
        int wait_cycles = -1;
        logic [2:0] prev_state;
        req_design = 4'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        while (md_rel < 30) tick();
        req_design = 4'd5; req_valid = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            prev_state = seq_state;
            tick();
            if (md_acc) req_valid = 1'b0;
            if (prev_state === 3'd0 && seq_state === 3'd1 && wait_cycles < 0) wait_cycles = k;
            n_cmp++; if (seq_state !== exp_state()) begin n_bad++; $display("FAIL hold_state k=%0d got %0d exp %0d", k, seq_state, exp_state()); end
            n_cmp++; if (design_select !== exp_sel()) begin n_bad++; $display("FAIL hold_select k=%0d got %0d exp %0d", k, design_select, exp_sel()); end
            if (md_rel == G + H + 3 && !req_valid) break;
        end
        n_cmp++; if (wait_cycles !== G + H + 3 - 30) begin n_bad++; $display("FAIL hold_accept_wait got %0d exp %0d", wait_cycles, G + H + 3 - 30); end
        n_cmp++; if (design_select !== 4'd5) begin n_bad++; $display("FAIL hold_final_select got %0d exp 5", design_select); end
    endtask

    task automatic test_reset_mid();
        req_design = 4'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        while (md_rel < 40) tick();
        #3 rst = 1'b1;
        #1;
        n_cmp++; if ({rst_force, pad_iso, done, req_err} !== 4'b0000) begin n_bad++; $display("FAIL midrst_outputs got %b exp 0000", {rst_force, pad_iso, done, req_err}); end
        n_cmp++; if (seq_state !== 3'd0) begin n_bad++; $display("FAIL midrst_state got %0d exp 0", seq_state); end
        n_cmp++; if (design_select !== 4'd0) begin n_bad++; $display("FAIL midrst_select got %0d exp 0", design_select); end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if ({seq_state, req_ready} !== 4'b0001) begin n_bad++; $display("FAIL midrst_after got %b exp 0001", {seq_state, req_ready}); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if (!req_valid && $urandom_range(0, 9) == 0) begin
                req_valid  = 1'b1;
                req_design = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            end
            wdt_kick = 1'($urandom_range(0, 1));
            tick();
            if (md_acc || md_err) req_valid = 1'b0;
            n_cmp++; if (seq_state !== exp_state()) begin n_bad++; $display("FAIL rand_state c=%0d got %0d exp %0d", c, seq_state, exp_state()); end
            n_cmp++; if (design_select !== exp_sel()) begin n_bad++; $display("FAIL rand_select c=%0d got %0d exp %0d", c, design_select, exp_sel()); end
            n_cmp++; if (pad_iso !== exp_pad()) begin n_bad++; $display("FAIL rand_pad_iso c=%0d got %b exp %b", c, pad_iso, exp_pad()); end
            n_cmp++; if (rst_force !== exp_pad()) begin n_bad++; $display("FAIL rand_rst_force c=%0d got %b exp %b", c, rst_force, exp_pad()); end
            n_cmp++; if (done !== exp_done()) begin n_bad++; $display("FAIL rand_done c=%0d got %b exp %b", c, done, exp_done()); end
            n_cmp++; if (req_err !== md_err) begin n_bad++; $display("FAIL rand_req_err c=%0d got %b exp %b", c, req_err, md_err); end
            n_cmp++; if (req_ready !== !exp_busy()) begin n_bad++; $display("FAIL rand_ready c=%0d got %b exp %b", c, req_ready, !exp_busy()); end
        end
        req_valid = 1'b0;
        wdt_kick  = 1'b0;
    endtask

    task automatic test_min_params();
        int done_k = -1;
        s_req_design = 4'd4; s_req_valid = 1'b1;
        tick();
        s_req_valid = 1'b0;
        n_cmp++; if ({s_pad_iso, s_rst_force} !== 2'b11) begin n_bad++; $display("FAIL min_iso got %b exp 11", {s_pad_iso, s_rst_force}); end
        n_cmp++; if (s_seq_state !== 3'd1) begin n_bad++; $display("FAIL min_state got %0d exp 1", s_seq_state); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (s_done === 1'b1 && done_k < 0) done_k = k;
            if (k == GM) begin
                n_cmp++; if (s_design_select !== 4'd0) begin n_bad++; $display("FAIL min_select_early got %0d exp 0", s_design_select); end
            end
            if (k == GM + 1) begin
                n_cmp++; if (s_design_select !== 4'd4) begin n_bad++; $display("FAIL min_select got %0d exp 4", s_design_select); end
            end
        end
        n_cmp++; if (done_k !== GM + HM + 2) begin n_bad++; $display("FAIL min_done_time got %0d exp %0d", done_k, GM + HM + 2); end
        n_cmp++; if ({s_seq_state, s_req_ready} !== 4'b0001) begin n_bad++; $display("FAIL min_idle got %b exp 0001", {s_seq_state, s_req_ready}); end
    endtask

    initial begin
        test_reset();
        test_first_sequence();
        test_reject();
        test_hold_ignored();
        test_reset_mid();
        test_random();
        test_min_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
